// File: rtl/posit_mul_result_pipe_8bit.sv
// Two-stage valid/ready output pipe that encodes a 14-bit extended posit product to posit8 (es=0).
// Optional NaR/zero delivery counters are enabled by defining POSIT_MUL_PIPE_STATS_EN.
`timescale 1ns/1ps

module encode_posit_8bit (
  input  logic [11:0] eposit,
  input  logic        guard,
  input  logic        summary,
  output logic [7:0]  posit
);
  logic [3:0]         exp_field;
  logic [4:0]         scale;
  logic               over;
  logic               under;
  logic [2:0]         shamt;
  logic signed [15:0] field;
  logic [15:0]        shifted;
  logic [6:0]         top;
  logic               rnd;
  logic               stk;
  logic               inc;
  logic [7:0]         mag;

  // Regime is formed by arithmetic-shifting a {seed,frac,guard} field, then round-to-nearest-even.
  always_comb begin
    exp_field = eposit[8:5];
    scale     = {1'b0, exp_field} - 5'd7;
    over      = ~scale[4] & (scale[3:0] > 4'd6);
    under     = (scale == 5'b11001);
    if (scale[4]) begin
      shamt = ~scale[2:0];
      field = {2'b01, eposit[4:0], guard, 8'h00};
    end else begin
      shamt = scale[2:0];
      field = {2'b10, eposit[4:0], guard, 8'h00};
    end
    shifted = 16'(field >>> shamt);
    top     = shifted[15:9];
    rnd     = shifted[8];
    stk     = (|shifted[7:0]) | summary;
    inc     = rnd & (stk | top[0]);
    mag     = {1'b0, top} + {7'd0, inc};
    // Posits never round to zero or NaR: clamp to minpos/maxpos outside the regime range.
    if (over) begin
      mag = 8'h7F;
    end else if (under) begin
      mag = 8'h01;
    end else begin
      mag = mag;
    end
    if (eposit[11]) begin
      posit = 8'h80;
    end else if (eposit[10]) begin
      posit = 8'h00;
    end else if (eposit[9]) begin
      posit = 8'h00 - mag;
    end else begin
      posit = mag;
    end
  end
endmodule

module posit_mul_result_pipe_8bit #(
  parameter int CNT_W  = 16
`ifdef POSIT_MUL_PIPE_STATS_EN
  , parameter int STAT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [13:0]       in_eproduct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_posit,
  output logic [CNT_W-1:0]  result_count
`ifdef POSIT_MUL_PIPE_STATS_EN
  , output logic [STAT_W-1:0] nar_count
  , output logic [STAT_W-1:0] zero_count
`endif
);
  logic              s1_valid_q, s1_valid_d;
  logic [13:0]       s1_data_q, s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [7:0]        out_posit_q, out_posit_d;
  logic [CNT_W-1:0]  result_count_q, result_count_d;
  logic              s2_ready;
  logic              out_fire;
  logic [7:0]        enc_posit;

  encode_posit_8bit u_encode (
    .eposit  (s1_data_q[13:2]),
    .guard   (s1_data_q[1]),
    .summary (s1_data_q[0]),
    .posit   (enc_posit)
  );

  assign s2_ready     = ~s2_valid_q | out_ready;
  assign in_ready     = ~s1_valid_q | s2_ready;
  assign out_fire     = s2_valid_q & out_ready;
  assign out_valid    = s2_valid_q;
  assign out_posit    = out_posit_q;
  assign result_count = result_count_q;

  // Next-state for both pipeline stages and the wrapping transfer counter.
  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_data_d      = s1_data_q;
    s2_valid_d     = s2_valid_q;
    out_posit_d    = out_posit_q;
    result_count_d = result_count_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_eproduct;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_posit_d = enc_posit;
      end else begin
        out_posit_d = out_posit_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (out_fire) begin
      result_count_d = result_count_q + CNT_W'(1);
    end else begin
      result_count_d = result_count_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_data_q      <= 14'h0000;
      s2_valid_q     <= 1'b0;
      out_posit_q    <= 8'h00;
      result_count_q <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_data_q      <= s1_data_d;
      s2_valid_q     <= s2_valid_d;
      out_posit_q    <= out_posit_d;
      result_count_q <= result_count_d;
    end
  end

`ifdef POSIT_MUL_PIPE_STATS_EN
  logic [STAT_W-1:0] nar_count_q, nar_count_d;
  logic [STAT_W-1:0] zero_count_q, zero_count_d;

  assign nar_count  = nar_count_q;
  assign zero_count = zero_count_q;

  // Saturating counters of delivered NaR and zero results.
  always_comb begin
    nar_count_d  = nar_count_q;
    zero_count_d = zero_count_q;
    if (out_fire && (out_posit_q == 8'h80) && (nar_count_q != {STAT_W{1'b1}})) begin
      nar_count_d = nar_count_q + STAT_W'(1);
    end else begin
      nar_count_d = nar_count_q;
    end
    if (out_fire && (out_posit_q == 8'h00) && (zero_count_q != {STAT_W{1'b1}})) begin
      zero_count_d = zero_count_q + STAT_W'(1);
    end else begin
      zero_count_d = zero_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nar_count_q  <= '0;
      zero_count_q <= '0;
    end else begin
      nar_count_q  <= nar_count_d;
      zero_count_q <= zero_count_d;
    end
  end
`endif
endmodule
